// File: rtl/decoder24_seq.sv
// Select-code sequencer feeding a 2-to-4 decoder: sweeps {A,B} through all
// four codes, holding each for DWELL cycles, in one-shot or continuous mode.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   start in  begin a sweep (sampled in IDLE only)
//   stop  in  abort a sweep (sampled in RUN, beats start)
//   mode  in  0 one-shot, 1 continuous (latched when start is accepted)
//   A, B  out registered select code, A is the MSB
//   en    out code on A/B is a valid sweep code
//   busy  out sequencer in RUN or DONE
//   done  out one-cycle pulse after a completed one-shot sweep
module decoder24_seq #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8,
   parameter bit GRAY  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   input  logic mode,
   output logic A,
   output logic B,
   output logic en,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx_nxt;
   logic             r_mode;
   logic             w_mode_nxt;
   logic             w_last;
   logic             w_run_nxt;
   logic [1:0]       w_ab;
   logic             r_a;
   logic             r_b;
   logic             r_en;
   logic             r_busy;
   logic             r_done;

   assign w_last = (r_cnt == LP_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_mode_nxt  = r_mode;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = 2'd0;
            if (start && !stop) begin
               w_state_nxt = S_RUN;
               w_mode_nxt  = mode;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 2'd0;
            end else if (w_last) begin
               w_cnt_nxt = '0;
               // index wraps 3->0 on its own; one-shot leaves RUN here
               w_idx_nxt = r_idx + 2'd1;
               if (r_idx == 2'd3 && !r_mode) begin
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
         end
      endcase
   end

   // outputs are derived from the next state so they land in the
   // same cycle as the state they describe
   assign w_run_nxt = (w_state_nxt == S_RUN);

   always_comb begin
      w_ab = 2'b00;
      if (w_run_nxt) begin
         if (GRAY) begin
            w_ab = {w_idx_nxt[1] ^ w_idx_nxt[0], w_idx_nxt[1]};
         end else begin
            w_ab = w_idx_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_mode  <= 1'b0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_mode  <= w_mode_nxt;
         r_a     <= w_ab[1];
         r_b     <= w_ab[0];
         r_en    <= w_run_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   assign A    = r_a;
   assign B    = r_b;
   assign en   = r_en;
   assign busy = r_busy;
   assign done = r_done;

endmodule
